// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU (clk, rst_n, in_valid/in_ready, A, B, func -> out_valid/out_ready, Y, flags{N,Z,C,V}); define ALU_MULH_EN to add func 10 mulh
module seq_alu #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   func,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [3:0]   flags
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t         state;
  logic [SHW-1:0] count;
  logic [3:0]     f_r;
  logic [N-1:0]   op, hi, lo;
  logic           multi, mul_in, mul_r, last, load;
  logic [N:0]     s_sum, shl_w, shr_w, m_sum, d_t, d_r;
  logic [N-1:0]   d_sub, y1, hi_n, lo_n, y_m, y_nx;
  logic [SHW-1:0] sh;
  logic           big, c1, v1, d_ge, c_m, v_m, c_nx, v_nx;
`ifdef ALU_MULH_EN
  assign multi  = func inside {4'd2, 4'd3, 4'd4, 4'd10};
  assign mul_in = func == 4'd2 || func == 4'd10;
  assign mul_r  = f_r == 4'd2 || f_r == 4'd10;
`else
  assign multi  = func inside {4'd2, 4'd3, 4'd4};
  assign mul_in = func == 4'd2;
  assign mul_r  = f_r == 4'd2;
`endif
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign last     = count == SHW'(N - 1);
  assign load     = (in_valid && in_ready && !multi) || (state == BUSY && last);
  assign s_sum    = {1'b0, A} + {1'b0, B};
  assign d_sub    = A - B;
  assign sh       = B[SHW-1:0];
  assign big      = |B[N-1:SHW];
  assign shl_w    = {1'b0, A} << sh;
  assign shr_w    = {A, 1'b0} >> sh;
  always_comb begin
    y1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (func)
      4'd0: begin
        y1 = s_sum[N-1:0];
        c1 = s_sum[N];
        v1 = (A[N-1] == B[N-1]) && (s_sum[N-1] != A[N-1]);
      end
      4'd1: begin
        y1 = d_sub;
        c1 = A >= B;
        v1 = (A[N-1] != B[N-1]) && (d_sub[N-1] != A[N-1]);
      end
      4'd5: y1 = A & B;
      4'd6: y1 = A | B;
      4'd7: y1 = A ^ B;
      4'd8: begin
        y1 = big ? '0 : shl_w[N-1:0];
        c1 = big ? (B == N'(N)) && A[0] : shl_w[N];
      end
      4'd9: begin
        y1 = big ? '0 : shr_w[N:1];
        c1 = !big && shr_w[0];
      end
      default: ;
    endcase
  end
  // mult: {hi,lo} shift-add with multiplier in lo; div/mod: restoring, hi = remainder, lo = dividend -> quotient
  assign m_sum = {1'b0, hi} + (lo[0] ? {1'b0, op} : '0);
  assign d_t   = {hi, lo[N-1]};
  assign d_ge  = d_t >= {1'b0, op};
  assign d_r   = d_t - {1'b0, op};
  assign hi_n  = mul_r ? m_sum[N:1] : (d_ge ? d_r[N-1:0] : d_t[N-1:0]);
  assign lo_n  = mul_r ? {m_sum[0], lo[N-1:1]} : {lo[N-2:0], d_ge};
  assign y_m   = (f_r == 4'd2 || f_r == 4'd3) ? lo_n : hi_n;
  assign c_m   = f_r == 4'd2 && |hi_n;
  assign v_m   = f_r == 4'd2 ? |hi_n : (f_r == 4'd3 || f_r == 4'd4) && op == '0;
  assign y_nx  = state == BUSY ? y_m : y1;
  assign c_nx  = state == BUSY ? c_m : c1;
  assign v_nx  = state == BUSY ? v_m : v1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      f_r       <= '0;
      op        <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      Y         <= '0;
      flags     <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        Y         <= y_nx;
        flags     <= {y_nx[N-1], y_nx == '0, c_nx, v_nx};
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        Y         <= '0;
        flags     <= '0;
      end
      if (state == IDLE) begin
        if (in_valid && in_ready && multi) begin
          state <= BUSY;
          count <= '0;
          f_r   <= func;
          op    <= mul_in ? A : B;
          hi    <= '0;
          lo    <= mul_in ? B : A;
        end
      end else begin
        hi    <= hi_n;
        lo    <= lo_n;
        count <= count + 1'b1;
        if (last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu (N=32)
module tb_seq_alu;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] A = '0, B = '0, Y;
  logic [3:0]  func = '0, flags;
  logic [35:0] sb[$];
  logic [35:0] e;
  int          n_chk = 0, n_fail = 0;
  seq_alu #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic pop_chk(input string tag);
    e = sb.size() > 0 ? sb.pop_front() : 36'hx_dead_beef;
    chk({tag, "_y"}, {4'h0, Y}, {4'h0, e[35:4]});
    chk({tag, "_flags"}, {32'h0, flags}, {32'h0, e[3:0]});
  endtask
  task automatic run(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic [3:0] ef, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 36'(in_ready), 36'd1);
    in_valid = 1'b1; A = a; B = b; func = f;
    sb.push_back({ey, ef});
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; func = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      chk({tag, "_busy_in_ready"}, 36'(in_ready), 36'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 36'(lat), 36'(elat));
    pop_chk(tag);
  endtask
  initial begin
    #12;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_y", {4'h0, Y}, 36'd0);
    chk("rst_flags", 36'(flags), 36'd0);
    chk("rst_in_ready", 36'(in_ready), 36'd1);
    @(negedge clk); rst_n = 1'b1;
    run("sum_ovf",  4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001, 1);
    run("sub_eq",   4'd1, 32'd5, 32'd5, 32'd0, 4'b0110, 1);
    run("sub_neg",  4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000, 1);
    run("mult_hi",  4'd2, 32'h10000, 32'h10000, 32'd0, 4'b0111, 33);
    run("mult",     4'd2, 32'd3, 32'd5, 32'd15, 4'b0000, 33);
    run("div",      4'd3, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
    run("mod",      4'd4, 32'd100, 32'd7, 32'd2, 4'b0000, 33);
    run("div0",     4'd3, 32'd9, 32'd0, 32'hFFFFFFFF, 4'b1001, 33);
    run("mod0",     4'd4, 32'd9, 32'd0, 32'd9, 4'b0001, 33);
    run("shl_n",    4'd8, 32'd1, 32'd32, 32'd0, 4'b0110, 1);
    run("shl_big",  4'd8, 32'd1, 32'd40, 32'd0, 4'b0100, 1);
    run("shr1",     4'd9, 32'h80000001, 32'd1, 32'h40000000, 4'b0010, 1);
    run("shr0",     4'd9, 32'h80000001, 32'd0, 32'h80000001, 4'b1000, 1);
    run("xor",      4'd7, 32'h1234, 32'h1234, 32'd0, 4'b0100, 1);
    run("illegal",  4'd12, 32'h5, 32'h6, 32'd0, 4'b0100, 1);
`ifdef ALU_MULH_EN
    run("mulh",     4'd10, 32'h10000, 32'h30000, 32'd3, 4'b0000, 33);
`else
    run("f10",      4'd10, 32'h10000, 32'h30000, 32'd0, 4'b0100, 1);
`endif
    // back-to-back single-cycle ops
    @(negedge clk);
    in_valid = 1'b1; func = 4'd5; A = 32'hF0F0; B = 32'hFF00;
    sb.push_back({32'hF000, 4'b0000});
    @(posedge clk); #1;
    func = 4'd6;
    sb.push_back({32'hFFF0, 4'b0000});
    @(negedge clk);
    chk("b2b_in_ready", 36'(in_ready), 36'd1);
    chk("b2b1_valid", 36'(out_valid), 36'd1);
    pop_chk("b2b1");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b2_valid", 36'(out_valid), 36'd1);
    pop_chk("b2b2");
    // backpressure
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; func = 4'd8; A = 32'd1; B = 32'd31;
    sb.push_back({32'h80000000, 4'b1000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    pop_chk("bp");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 36'(out_valid), 36'd1);
      chk("bp_hold", {Y, flags}, {32'h80000000, 4'b1000});
      chk("bp_in_ready", 36'(in_ready), 36'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; func = 4'd0; A = 32'd2; B = 32'd3;
    sb.push_back({32'd5, 4'b0000});
    #1;
    chk("bp_release_in_ready", 36'(in_ready), 36'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 36'(out_valid), 36'd1);
    pop_chk("bp_next");
    // reset during a division
    @(negedge clk);
    in_valid = 1'b1; func = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 36'(in_ready), 36'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 36'(out_valid), 36'd0);
    chk("abort_y", {4'h0, Y}, 36'd0);
    chk("abort_flags", 36'(flags), 36'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 36'(in_ready), 36'd1);
    run("post_rst_sum", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
    repeat (40) @(negedge clk);
    chk("no_stray_valid", 36'(out_valid), 36'd0);
    chk("sb_empty", 36'(sb.size()), 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle, handshaked successor of the combinational processor ALU, parametrised in width N.
- Keeps the same 4-bit opcode map and 4-bit flag encoding. Add, sub, logic and shift ops complete in one cycle; mult, div and mod use an iterative N-step shift-add or restoring datapath.
- Sits between the decode/register-read stage and write-back; the pipeline stalls on in_ready and out_valid.

Parameters:
- N, 32, operand/result width (N >= 4, power of two)
- SHW, $clog2(N), width of the shift-amount field taken from B

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/func presented
- in_ready  out  1  block can accept an operation this cycle
- A  in  N  operand A (unsigned unless stated)
- B  in  N  operand B
- func  in  4  0 sum, 1 sub, 2 mult, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 shl, 9 shr
- out_valid  out  1  Y/flags valid
- out_ready  in  1  consumer takes the result
- Y  out  N  result (registered)
- flags  out  4  bit0 overflow, bit1 carry, bit2 zero, bit3 negative (registered)

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid=0, Y=0, flags=0, in_ready=1. Reset mid-iteration aborts the operation with no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept happens when in_valid && in_ready at a rising edge; A, B and func are latched at that edge.
- States:
  - IDLE: single-cycle op accepted → result loads into Y/flags at the same edge, so out_valid=1 in the next cycle (latency 1). Mult/div/mod accepted → BUSY, count=0.
  - BUSY: one iteration per cycle, count increments. When count==N-1, the result loads into Y/flags and the state returns to IDLE. Latency is N+1 cycles from accept to out_valid; in_ready=0 throughout.
- Output hold: while out_valid && !out_ready, Y/flags are stable. Result register is cleared when out_valid && out_ready and no new result is loading at that edge. Back-to-back single-cycle ops sustain 1 op/cycle.
- Flag rules:
  - Z: (Y==0) for every op.
  - N: Y[N-1] for every op.
  - sum: C = carry out of bit N-1; V = signed overflow.
  - sub: C = 1 when A>=B (no borrow); V = signed overflow of A-B.
  - mult: Y = low N bits of the product; C = V = (high N bits != 0).
  - div/mod: Y = A/B or A%B; C = V = 0, except when B==0.
  - B==0 on div/mod: Y = all ones for div, Y = A for mod, V=1, C=0. Takes the full N+1 cycle latency.
  - and/or/xor: C = V = 0.
  - shl/shr: amount = B[SHW-1:0]. If B >= N, Y=0 and C = A bit that would be shifted out last (A[0] for shl when B==N, otherwise 0). For amounts 1..N-1, C = last bit shifted out. Amount 0 gives Y=A, C=0. V=0; shr is logical.
- Illegal func (10..15): treated as single-cycle, Y=0, flags=0100 (Z=1).
- No input changes affect an operation after acceptance.

Optional Feature:
- Macro ALU_MULH_EN.
- When defined: func 10 = mulh. Multi-cycle, same latency as mult; Y = high N bits of the unsigned product. C = V = 0; Z and N follow Y.
- When undefined: func 10 is illegal (Y=0, flags=0100), and no extra product register bits are kept beyond what mult needs.

Test Plan:
- N=32, sum A=0x7FFFFFFF B=1 → one cycle after accept: Y=0x80000000, flags=1001.
- sub A=5 B=5 → Y=0, flags=0110. Then sub A=3 B=5 → Y=0xFFFFFFFE, flags=1000.
- mult A=0x10000 B=0x10000 → out_valid exactly 33 cycles after accept, Y=0, flags=0111. The in_ready=0 window is checked for the entire BUSY period.
- div A=100 B=7 → Y=14 after 33 cycles. mod with the same operands → Y=2. div A=9 B=0 → Y=0xFFFFFFFF, flags=1001.
- Backpressure: shl A=1 B=31 with out_ready held low for 5 cycles → Y=0x80000000, flags=1000 stable throughout, in_ready=0. After out_ready rises, the next op is accepted in the same cycle.
- rst_n pulled low at cycle 10 of a div → out_valid=0, Y=0, flags=0 immediately. After release, in_ready=1 and a sum 2+3 returns Y=5.
